// File: rtl/seq_divider8.sv
// seq_divider8: sequential unsigned restoring divider.
//
// Shifts a {remainder, quotient} pair left one bit per cycle, feeding each new
// quotient bit in at the LSB. A divide-by-zero request skips the iterations
// entirely and reports quotient = all ones, remainder = dividend.
//
// Ports:
//   clk          system clock, rising edge
//   clr_n        asynchronous active-low reset
//   start        division request, sampled only while idle
//   dividend     numerator, captured on the accepting edge
//   divisor      denominator, captured on the accepting edge
//   quotient     registered result, held until the next completion
//   remainder    registered result, held until the next completion
//   busy         high while calculating and during the done cycle
//   done         one-cycle completion pulse
//   div_by_zero  registered flag, updated together with the results
module seq_divider8 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    state_t           state_q;
    logic [WIDTH:0]   a_q;      // partial remainder incl. borrow bit
    logic [WIDTH-1:0] q_q;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] d_q;      // latched divisor
    logic [3:0]       cnt_q;

    logic [WIDTH:0]   a_shift;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH:0]   a_next;
    logic [WIDTH-1:0] q_next;
    logic             last_iter;

    // One restoring step: subtract only when the result stays non-negative.
    always_comb begin
        a_shift   = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
        trial     = a_shift - {1'b0, d_q};
        fits      = ~trial[WIDTH];
        a_next    = fits ? trial : a_shift;
        q_next    = {q_q[WIDTH-2:0], fits};
        last_iter = (cnt_q == 4'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor != '0) begin
                            a_q     <= '0;
                            q_q     <= dividend;
                            d_q     <= divisor;
                            cnt_q   <= '0;
                            state_q <= StCalc;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state_q     <= StDone;
                        end
                    end
                end
                StCalc: begin
                    a_q   <= a_next;
                    q_q   <= q_next;
                    cnt_q <= cnt_q + 4'd1;
                    if (last_iter) begin
                        quotient    <= q_next;
                        remainder   <= a_next[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider8.sv
module tb_seq_divider8;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider8 #(.WIDTH(8)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer division.
    function automatic logic [16:0] model(input int a, input int b);
        if (b == 0) return {1'b1, 8'hFF, 8'(a)};
        return {1'b0, 8'(a / b), 8'(a % b)};
    endfunction

    // Issue one request and follow it until busy drops. Optionally pulse a
    // second request at negedge number pulse_at after the accepting edge.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input int pulse_at, input logic [7:0] pa, input logic [7:0] pb,
                          output int lat, output int busy_cyc, output int dones);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        lat = 0; busy_cyc = 0; dones = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            dividend = 8'($urandom);
            divisor  = 8'($urandom);
            if (i == pulse_at) begin
                start = 1'b1; dividend = pa; divisor = pb;
            end
            if (busy) busy_cyc++;
            if (done) begin
                dones++;
                if (lat == 0) lat = i;
            end
            if (!busy) begin
                start = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clr_n = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({quotient, remainder, busy, done, div_by_zero} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0",
                     quotient, remainder, busy, done, div_by_zero);
        end
        // Release together with a request: the very next edge must accept it.
        clr_n = 1'b1; start = 1'b1; dividend = 8'd10; divisor = 8'd3;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_accept: got busy=%b, want 1", busy);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if ({quotient, remainder} !== {8'd3, 8'd1} || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_result: got q=%0d r=%0d busy=%b, want q=3 r=1 busy=0",
                     quotient, remainder, busy);
        end
    endtask

    task automatic test_basic();
        int lat, bc, nd;
        run_op(8'd200, 8'd7, 0, 8'd0, 8'd0, lat, bc, nd);
        n_checks++;
        if (lat !== 9 || bc !== 9 || nd !== 1) begin
            n_fail++;
            $display("FAIL basic_timing: got latency=%0d busy_cycles=%0d dones=%0d, want 9 9 1",
                     lat, bc, nd);
        end
        n_checks++;
        if ({div_by_zero, quotient, remainder} !== {1'b0, 8'd28, 8'd4}) begin
            n_fail++;
            $display("FAIL basic_result: got q=%0d r=%0d dbz=%b, want q=28 r=4 dbz=0",
                     quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] ta [4] = '{8'd255, 8'd5, 8'd0, 8'd255};
        logic [7:0] tb [4] = '{8'd1,   8'd9, 8'd3, 8'd255};
        logic [7:0] eq [4] = '{8'd255, 8'd0, 8'd0, 8'd1};
        logic [7:0] er [4] = '{8'd0,   8'd5, 8'd0, 8'd0};
        int lat, bc, nd;
        for (int k = 0; k < 4; k++) begin
            run_op(ta[k], tb[k], 0, 8'd0, 8'd0, lat, bc, nd);
            n_checks++;
            if ({quotient, remainder, div_by_zero} !== {eq[k], er[k], 1'b0} || lat !== 9) begin
                n_fail++;
                $display("FAIL boundary_%0d_%0d: got q=%0d r=%0d dbz=%b lat=%0d, want q=%0d r=%0d dbz=0 lat=9",
                         ta[k], tb[k], quotient, remainder, div_by_zero, lat, eq[k], er[k]);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat, bc, nd;
        run_op(8'd77, 8'd0, 0, 8'd0, 8'd0, lat, bc, nd);
        n_checks++;
        if (lat !== 1 || bc !== 1 || nd !== 1) begin
            n_fail++;
            $display("FAIL dbz_timing: got latency=%0d busy_cycles=%0d dones=%0d, want 1 1 1",
                     lat, bc, nd);
        end
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== {8'hFF, 8'd77, 1'b1}) begin
            n_fail++;
            $display("FAIL dbz_result: got q=%0d r=%0d dbz=%b, want q=255 r=77 dbz=1",
                     quotient, remainder, div_by_zero);
        end
        run_op(8'd9, 8'd3, 0, 8'd0, 8'd0, lat, bc, nd);
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== {8'd3, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL dbz_clear: got q=%0d r=%0d dbz=%b, want q=3 r=0 dbz=0",
                     quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_ignore_start();
        int lat, bc, nd;
        run_op(8'd50, 8'd7, 3, 8'd100, 8'd10, lat, bc, nd);
        @(negedge clk);
        n_checks++;
        if ({quotient, remainder} !== {8'd7, 8'd1} || nd !== 1 || bc !== 9 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start: got q=%0d r=%0d dones=%0d busy_cycles=%0d busy=%b, want 7 1 1 9 0",
                     quotient, remainder, nd, bc, busy);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc, nd;
        int seen_done = 0;
        @(negedge clk);
        dividend = 8'd200; divisor = 8'd7; start = 1'b1;
        @(posedge clk);
        repeat (4) @(negedge clk);
        start = 1'b0;
        clr_n = 1'b0;
        #1;
        n_checks++;
        if ({quotient, remainder, busy, done, div_by_zero} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0",
                     quotient, remainder, busy, done, div_by_zero);
        end
        @(negedge clk);
        clr_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        n_checks++;
        if (seen_done !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: got dones=%0d busy=%b, want 0 0", seen_done, busy);
        end
        run_op(8'd13, 8'd4, 0, 8'd0, 8'd0, lat, bc, nd);
        n_checks++;
        if ({quotient, remainder} !== {8'd3, 8'd1} || nd !== 1) begin
            n_fail++;
            $display("FAIL reset_mid_restart: got q=%0d r=%0d dones=%0d, want 3 1 1",
                     quotient, remainder, nd);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] qa[$];
        logic [7:0] qb[$];
        logic [16:0] exp_v;
        logic [7:0] a, b;
        int ndone = 0, last = -1, cyc = 0;
        @(negedge clk);
        while (ndone < 1000 && cyc < 12000) begin
            dividend = 8'($urandom);
            divisor  = 8'($urandom_range(255, 1));
            start    = 1'b1;
            // While idle, the next edge accepts whatever is driven now.
            if (!busy) begin
                qa.push_back(dividend);
                qb.push_back(divisor);
            end
            @(negedge clk);
            cyc++;
            if (done) begin
                n_checks++;
                if (qa.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_unexpected_done: got done at cycle %0d, want no request pending",
                             cyc);
                end else begin
                    a = qa.pop_front();
                    b = qb.pop_front();
                    exp_v = model(int'(a), int'(b));
                    if ({div_by_zero, quotient, remainder} !== exp_v ||
                        16'(quotient) * 16'(b) + 16'(remainder) !== 16'(a) || remainder >= b) begin
                        n_fail++;
                        $display("FAIL b2b_result %0d/%0d: got q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=0",
                                 a, b, quotient, remainder, div_by_zero, exp_v[15:8], exp_v[7:0]);
                    end
                end
                if (last >= 0) begin
                    n_checks++;
                    if (cyc - last !== 10) begin
                        n_fail++;
                        $display("FAIL b2b_period: got %0d cycles between done pulses, want 10",
                                 cyc - last);
                    end
                end
                last = cyc;
                ndone++;
            end
        end
        start = 1'b0;
        n_checks++;
        if (ndone !== 1000) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d completions, want 1000", ndone);
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
